// File: rtl/rx_lock_controller_pkg.sv
// Shared constants for the PCIE receive-lock path: K28.5 codes, link state encodings
// and the default lock/slip/error-window parameters.
package rx_lock_controller_pkg;

  localparam logic [9:0] K285_RDN = 10'b0011111010;
  localparam logic [9:0] K285_RDP = 10'b1100000101;

  typedef enum logic [2:0] {
    LS_HUNT   = 3'd0,
    LS_SETTLE = 3'd1,
    LS_VERIFY = 3'd2,
    LS_LOCKED = 3'd3
  } linkState_e;

  localparam int unsigned DEF_LOCK_COMMAS = 4;
  localparam int unsigned DEF_HUNT_SYMS   = 16;
  localparam int unsigned DEF_SLIP_SETTLE = 2;
  localparam int unsigned DEF_ERR_LIMIT   = 4;
  localparam int unsigned DEF_WINDOW      = 64;

  function automatic logic isComma(input logic [9:0] sym);
    return (sym == K285_RDN) || (sym == K285_RDP);
  endfunction

endpackage

// File: rtl/rx_lock_controller_err_window.sv
// LOCKED-state decode error window: counts strobes and errors, flags the strobe whose
// error pushes the count to the limit, and restarts the window every WINDOW strobes.
module rx_err_window
  import rx_lock_controller_pkg::*;
#(
  parameter int unsigned ERR_LIMIT = DEF_ERR_LIMIT,
  parameter int unsigned WINDOW    = DEF_WINDOW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       strobe,
  input  logic       invalid,
  output logic [2:0] errCnt,
  output logic       limitHit
);

  localparam int unsigned WIN_W = $clog2(WINDOW) + 1;

  logic [WIN_W-1:0] winCnt_r;
  logic [2:0]       errCnt_r;
  logic [2:0]       errNext_s;
  logic             winEnd_s;

  // Next error count (saturating) and the limit / window-end decisions for this strobe
  always_comb begin
    errNext_s = errCnt_r;
    if (invalid && (errCnt_r != 3'd7)) begin
      errNext_s = errCnt_r + 3'd1;
    end else begin
      errNext_s = errCnt_r;
    end
    winEnd_s = (winCnt_r == WIN_W'(WINDOW - 1));
    limitHit = strobe && (32'(errNext_s) >= ERR_LIMIT);
  end

  // Window and error counters; an error on the closing strobe carries into the new window
  always_ff @(posedge clk) begin
    if (rst) begin
      winCnt_r <= {WIN_W{1'b0}};
      errCnt_r <= 3'd0;
    end else if (enb && strobe) begin
      if (limitHit) begin
        winCnt_r <= {WIN_W{1'b0}};
        errCnt_r <= 3'd0;
      end else if (winEnd_s) begin
        winCnt_r <= {WIN_W{1'b0}};
        errCnt_r <= {2'b00, invalid};
      end else begin
        winCnt_r <= winCnt_r + WIN_W'(1);
        errCnt_r <= errNext_s;
      end
    end
  end

  assign errCnt = errCnt_r;

endmodule

// File: rtl/rx_lock_controller.sv
// Receive link-lock sequencer: hunts for K28.5 framing by commanding bit slips,
// verifies repeated aligned commas, and drops lock on an excessive decode error rate.
module rx_lock_controller
  import rx_lock_controller_pkg::*;
#(
  parameter int unsigned LOCK_COMMAS = DEF_LOCK_COMMAS,
  parameter int unsigned HUNT_SYMS   = DEF_HUNT_SYMS,
  parameter int unsigned SLIP_SETTLE = DEF_SLIP_SETTLE,
  parameter int unsigned ERR_LIMIT   = DEF_ERR_LIMIT,
  parameter int unsigned WINDOW      = DEF_WINDOW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       symStrobe,
  input  logic [9:0] symbolIn,
  input  logic       invalidIn,
  output logic       slip,
  output logic       rxValid,
  output logic [2:0] linkState,
  output logic       lockLost,
  output logic [2:0] errCnt
);

  localparam int unsigned SYM_W = $clog2(HUNT_SYMS) + 1;
  localparam int unsigned SET_W = $clog2(SLIP_SETTLE) + 1;
  localparam int unsigned COM_W = $clog2(LOCK_COMMAS) + 1;

  linkState_e       state_r;
  logic [SYM_W-1:0] symCnt_r;
  logic [SET_W-1:0] settleCnt_r;
  logic [COM_W-1:0] commaCnt_r;
  logic             winStrobe_s;
  logic             limitHit_s;

  assign winStrobe_s = symStrobe && (state_r == LS_LOCKED);
  assign linkState   = state_r;

  rx_err_window #(
    .ERR_LIMIT (ERR_LIMIT),
    .WINDOW    (WINDOW)
  ) u_errWindow (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .strobe   (winStrobe_s),
    .invalid  (invalidIn),
    .errCnt   (errCnt),
    .limitHit (limitHit_s)
  );

  // Lock FSM; slip and lockLost are single-cycle pulses cleared on every non-reset edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= LS_HUNT;
      symCnt_r    <= {SYM_W{1'b0}};
      settleCnt_r <= {SET_W{1'b0}};
      commaCnt_r  <= {COM_W{1'b0}};
      slip        <= 1'b0;
      rxValid     <= 1'b0;
      lockLost    <= 1'b0;
    end else begin
      slip     <= 1'b0;
      lockLost <= 1'b0;
      if (enb && symStrobe) begin
        case (state_r)
          LS_HUNT: begin
            if (isComma(symbolIn)) begin
              state_r    <= LS_VERIFY;
              commaCnt_r <= COM_W'(1);
              symCnt_r   <= {SYM_W{1'b0}};
            end else if (symCnt_r == SYM_W'(HUNT_SYMS - 1)) begin
              slip     <= 1'b1;
              state_r  <= LS_SETTLE;
              symCnt_r <= {SYM_W{1'b0}};
            end else begin
              symCnt_r <= symCnt_r + SYM_W'(1);
            end
          end
          LS_SETTLE: begin
            if (settleCnt_r == SET_W'(SLIP_SETTLE - 1)) begin
              state_r     <= LS_HUNT;
              settleCnt_r <= {SET_W{1'b0}};
            end else begin
              settleCnt_r <= settleCnt_r + SET_W'(1);
            end
          end
          LS_VERIFY: begin
            if (invalidIn) begin
              slip       <= 1'b1;
              state_r    <= LS_SETTLE;
              commaCnt_r <= {COM_W{1'b0}};
            end else if (isComma(symbolIn)) begin
              if (commaCnt_r == COM_W'(LOCK_COMMAS - 1)) begin
                state_r    <= LS_LOCKED;
                rxValid    <= 1'b1;
                commaCnt_r <= {COM_W{1'b0}};
              end else begin
                commaCnt_r <= commaCnt_r + COM_W'(1);
              end
            end
          end
          LS_LOCKED: begin
            if (limitHit_s) begin
              state_r  <= LS_HUNT;
              rxValid  <= 1'b0;
              lockLost <= 1'b1;
            end
          end
          default: begin
            state_r     <= LS_HUNT;
            rxValid     <= 1'b0;
            symCnt_r    <= {SYM_W{1'b0}};
            settleCnt_r <= {SET_W{1'b0}};
            commaCnt_r  <= {COM_W{1'b0}};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_lock_controller.sv
// Randomized scoreboard bench for rx_lock_controller: a behavioural link model predicts
// every cycle's outputs into a queue that an independent monitor drains and compares.
module tb_rx_lock_controller;
  import rx_lock_controller_pkg::*;

  localparam int LOCK_COMMAS = DEF_LOCK_COMMAS;
  localparam int HUNT_SYMS   = DEF_HUNT_SYMS;
  localparam int SLIP_SETTLE = DEF_SLIP_SETTLE;
  localparam int ERR_LIMIT   = DEF_ERR_LIMIT;
  localparam int WINDOW      = DEF_WINDOW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb = 1'b0;
  logic       symStrobe = 1'b0;
  logic [9:0] symbolIn = 10'd0;
  logic       invalidIn = 1'b0;
  logic       slip, rxValid, lockLost;
  logic [2:0] linkState, errCnt;

  rx_lock_controller dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .symStrobe (symStrobe),
    .symbolIn  (symbolIn),
    .invalidIn (invalidIn),
    .slip      (slip),
    .rxValid   (rxValid),
    .linkState (linkState),
    .lockLost  (lockLost),
    .errCnt    (errCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       slip;
    logic       rxValid;
    logic [2:0] linkState;
    logic       lockLost;
    logic [2:0] errCnt;
  } exp_t;

  exp_t expQ[$];
  int compared   = 0;
  int mismatched = 0;

  // Reference model: 0 hunting, 1 settling after slip, 2 verifying, 3 locked
  int mMode = 0, mSeen = 0, mSettle = 0, mCommas = 0, mWinPos = 0, mErrs = 0;
  bit mSlip = 0, mLost = 0;

  task automatic modelStep(input bit r, input bit e, input bit s, input logic [9:0] sym, input bit inv);
    bit   comma;
    int   errs;
    exp_t x;
    comma = (sym == K285_RDN) || (sym == K285_RDP);
    mSlip = 0;
    mLost = 0;
    if (r) begin
      mMode = 0; mSeen = 0; mSettle = 0; mCommas = 0; mWinPos = 0; mErrs = 0;
    end else if (e && s) begin
      case (mMode)
        0: if (comma) begin
             mMode = 2; mCommas = 1; mSeen = 0;
           end else begin
             mSeen++;
             if (mSeen == HUNT_SYMS) begin mSlip = 1; mMode = 1; mSeen = 0; end
           end
        1: begin
             mSettle++;
             if (mSettle == SLIP_SETTLE) begin mMode = 0; mSettle = 0; end
           end
        2: if (inv) begin
             mSlip = 1; mMode = 1; mCommas = 0;
           end else if (comma) begin
             mCommas++;
             if (mCommas == LOCK_COMMAS) begin mMode = 3; mCommas = 0; mWinPos = 0; mErrs = 0; end
           end
        default: begin
             errs = mErrs + (inv ? 1 : 0);
             if (errs >= ERR_LIMIT) begin
               mMode = 0; mLost = 1; mWinPos = 0; mErrs = 0;
             end else if (mWinPos + 1 == WINDOW) begin
               mWinPos = 0; mErrs = inv ? 1 : 0;
             end else begin
               mWinPos++; mErrs = errs;
             end
           end
      endcase
    end
    x.slip      = mSlip;
    x.rxValid   = (mMode == 3);
    x.linkState = 3'(mMode);
    x.lockLost  = mLost;
    x.errCnt    = (mErrs > 7) ? 3'd7 : 3'(mErrs);
    expQ.push_back(x);
  endtask

  task automatic step(input bit r, input bit e, input bit s, input logic [9:0] sym, input bit inv);
    @(negedge clk);
    rst = r; enb = e; symStrobe = s; symbolIn = sym; invalidIn = inv;
    modelStep(r, e, s, sym, inv);
  endtask

  function automatic logic [9:0] randData();
    logic [9:0] d;
    d = 10'($urandom_range(0, 1023));
    if (d == K285_RDN || d == K285_RDP) d = 10'h000;
    return d;
  endfunction

  function automatic logic [9:0] randComma();
    return ($urandom_range(0, 1) == 1) ? K285_RDP : K285_RDN;
  endfunction

  task automatic strobeSym(input logic [9:0] sym, input bit inv, input int gap);
    step(1'b0, 1'b1, 1'b1, sym, inv);
    for (int g = 0; g < gap; g++) step(1'b0, 1'b1, 1'b0, randData(), 1'($urandom_range(0, 1)));
  endtask

  task automatic doReset();
    step(1'b1, 1'b1, 1'b0, randData(), 1'b0);
    step(1'b1, 1'b0, 1'b1, randData(), 1'b1);
  endtask

  task automatic lockUp();
    for (int i = 0; i < LOCK_COMMAS; i++) strobeSym(randComma(), 1'b0, 0);
  endtask

  // Monitor: one predicted output set per clock, compared just after the edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      compared++;
      if (slip !== e.slip || rxValid !== e.rxValid || linkState !== e.linkState ||
          lockLost !== e.lockLost || errCnt !== e.errCnt) begin
        mismatched++;
        if (mismatched <= 20)
          $display("FAIL outputs t=%0t got slip=%b rxValid=%b linkState=%0d lockLost=%b errCnt=%0d exp slip=%b rxValid=%b linkState=%0d lockLost=%b errCnt=%0d",
                   $time, slip, rxValid, linkState, lockLost, errCnt,
                   e.slip, e.rxValid, e.linkState, e.lockLost, e.errCnt);
      end
    end
  end

  initial begin
    int p0, p1, p2;
    doReset();

    // Aligned stream, comma every 4th symbol
    for (int i = 0; i < 24; i++)
      strobeSym((i % 4 == 0) ? randComma() : randData(), 1'b0, $urandom_range(0, 2));

    // No comma, strobe every 10 clocks
    doReset();
    for (int i = 0; i < 40; i++) strobeSym(randData(), 1'b0, 9);

    // VERIFY hit by a decode error on its 2nd symbol, then settle and lock
    doReset();
    strobeSym(randComma(), 1'b0, 1);
    strobeSym(randData(), 1'b1, 1);
    strobeSym(randComma(), 1'b0, 0);
    strobeSym(randComma(), 1'b0, 0);
    lockUp();

    // Five windows of three errors each stay locked
    for (int w = 0; w < 5; w++) begin
      p0 = $urandom_range(0, WINDOW - 2);
      do p1 = $urandom_range(0, WINDOW - 2); while (p1 == p0);
      do p2 = $urandom_range(0, WINDOW - 2); while (p2 == p0 || p2 == p1);
      for (int k = 0; k < WINDOW; k++) strobeSym(randData(), (k == p0 || k == p1 || k == p2), 0);
    end

    // Error on the closing strobe carries one error into the next window, then loss
    for (int k = 0; k < WINDOW; k++) strobeSym(randData(), (k == 10 || k == 20 || k == WINDOW - 1), 0);
    for (int k = 0; k < 8; k++) strobeSym(randData(), (k >= 5), 0);

    // Four errors inside one window
    doReset();
    lockUp();
    for (int k = 0; k < 40; k++) strobeSym(randData(), (k == 1 || k == 9 || k == 17 || k == 30), 0);

    // enb low freezes HUNT, and drops a slip pulse the cycle after it issues
    doReset();
    for (int i = 0; i < 10; i++) strobeSym(randData(), 1'b0, 0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1, randData(), 1'b0);
    for (int i = 0; i < 6; i++) strobeSym(randData(), 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, randData(), 1'b0);
    step(1'b0, 1'b0, 1'b0, randData(), 1'b0);

    // Reset while locked with enb low
    doReset();
    lockUp();
    strobeSym(randData(), 1'b1, 0);
    step(1'b1, 1'b0, 1'b1, randData(), 1'b1);
    step(1'b0, 1'b0, 1'b0, randData(), 1'b0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++)
      step(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? randComma() : randData(), 1'($urandom_range(0, 29) == 0));

    repeat (3) @(negedge clk);
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("FAIL drain got %0d pending exp 0 pending", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
